// File: rtl/aska_pkg.sv
// Shared types and helpers for the H-bridge output stage.
// State encoding, default widths and the shoot-through check.
package aska_pkg;

  localparam int ELEC_W_DEF = 32;
  localparam int DAC_W_DEF  = 6;
  localparam int ELEC_MAX   = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD,
    ST_DRIVE,
    ST_DISCH,
    ST_FAULT
  } hb_state_e;

  // Any electrode asked for on both P and N would short the supply.
  function automatic logic pat_overlap(
    input logic [ELEC_MAX-1:0] p,
    input logic [ELEC_MAX-1:0] n
  );
    return |(p & n);
  endfunction

endpackage

// File: rtl/aska_hb_timer.sv
// Loadable down-counter with zero flag.
// Shared between dead-time and discharge intervals.
module aska_hb_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Saturates at zero: an idle timer never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/aska_hbridge_drv.sv
// H-bridge output stage: dead time, passive discharge and
// shoot-through / compliance fault latching.
module aska_hbridge_drv
  import aska_pkg::*;
#(
  parameter int ELEC_W       = ELEC_W_DEF,
  parameter int DAC_W        = DAC_W_DEF,
  parameter int DEAD_CYCLES  = 2,
  parameter int DISCH_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ELEC_W-1:0] up_req,
  input  logic [ELEC_W-1:0] down_req,
  input  logic [DAC_W-1:0]  dac_in,
  input  logic              fault_in,
  input  logic              fault_clear,
  output logic [ELEC_W-1:0] up_sw,
  output logic [ELEC_W-1:0] down_sw,
  output logic [DAC_W-1:0]  dac_out,
  output logic              discharge_active,
  output logic              fault,
  output logic              busy
);

  localparam int CMAX =
    (DEAD_CYCLES > DISCH_CYCLES) ? DEAD_CYCLES : DISCH_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DEAD_LD  = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] DISCH_LD = CW'(DISCH_CYCLES - 1);

  // A 1-cycle interphase gap must fall inside dead time.
  if (DEAD_CYCLES < 2) begin : g_bad_dead
    $error("DEAD_CYCLES must be >= 2");
  end
  if (DISCH_CYCLES < 1) begin : g_bad_disch
    $error("DISCH_CYCLES must be >= 1");
  end
  if (ELEC_W > ELEC_MAX) begin : g_bad_elec
    $error("ELEC_W exceeds ELEC_MAX");
  end

  hb_state_e         state;
  hb_state_e         nxt;
  logic [ELEC_W-1:0] disch_mask;
  logic              req_nz;
  logic              illegal;
  logic              pat_chg;
  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_zero;
  logic [CW-1:0]     tmr_val;

  assign req_nz  = |(up_req | down_req);
  assign illegal = pat_overlap(ELEC_MAX'(up_req),
                               ELEC_MAX'(down_req));
  assign pat_chg = {up_req, down_req} != {up_sw, down_sw};

  always_comb begin
    nxt = state;
    if (illegal || fault_in) begin
      nxt = ST_FAULT;
    end else if (state == ST_FAULT) begin
      if (fault_clear && !req_nz) nxt = ST_IDLE;
    end else if (!enable) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (req_nz) nxt = ST_DEAD;
        ST_DEAD:  if (tmr_zero)
                    nxt = req_nz ? ST_DRIVE : ST_DISCH;
        ST_DRIVE: if (pat_chg) nxt = ST_DEAD;
        ST_DISCH: begin
          if (req_nz)        nxt = ST_DEAD;
          else if (tmr_zero) nxt = ST_IDLE;
        end
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  assign tmr_load = (nxt == ST_DEAD  && state != ST_DEAD) ||
                    (nxt == ST_DISCH && state != ST_DISCH);
  assign tmr_val  = (nxt == ST_DISCH) ? DISCH_LD : DEAD_LD;
  assign tmr_dec  = (state == ST_DEAD) || (state == ST_DISCH);

  aska_hb_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      up_sw            <= '0;
      down_sw          <= '0;
      dac_out          <= '0;
      disch_mask       <= '0;
      discharge_active <= 1'b0;
      fault            <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= nxt;
      fault            <= (nxt == ST_FAULT);
      discharge_active <= (nxt == ST_DISCH);
      busy             <= (nxt == ST_DEAD) ||
                          (nxt == ST_DRIVE) ||
                          (nxt == ST_DISCH);
      if (nxt == ST_IDLE) begin
        disch_mask <= '0;
      end else if (state == ST_DRIVE) begin
        disch_mask <= disch_mask | up_sw | down_sw;
      end
      unique case (nxt)
        ST_DRIVE: begin
          if (state != ST_DRIVE) begin
            up_sw   <= up_req;
            down_sw <= down_req;
          end
          dac_out <= dac_in;
        end
        ST_DISCH: begin
          up_sw   <= '0;
          down_sw <= disch_mask;
          dac_out <= '0;
        end
        default: begin
          up_sw   <= '0;
          down_sw <= '0;
          dac_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aska_hbridge_drv.sv
// Randomised bench for aska_hbridge_drv against a
// rule-level reference model of dead time / discharge / fault.
module tb_aska_hbridge_drv;

  localparam int EW    = 32;
  localparam int DW    = 6;
  localparam int DEAD  = 2;
  localparam int DISCH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [EW-1:0] up_req;
  logic [EW-1:0] down_req;
  logic [DW-1:0] dac_in;
  logic          fault_in;
  logic          fault_clear;
  logic [EW-1:0] up_sw;
  logic [EW-1:0] down_sw;
  logic [DW-1:0] dac_out;
  logic          discharge_active;
  logic          fault;
  logic          busy;

  aska_hbridge_drv #(
    .ELEC_W       (EW),
    .DAC_W        (DW),
    .DEAD_CYCLES  (DEAD),
    .DISCH_CYCLES (DISCH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .up_req           (up_req),
    .down_req         (down_req),
    .dac_in           (dac_in),
    .fault_in         (fault_in),
    .fault_clear      (fault_clear),
    .up_sw            (up_sw),
    .down_sw          (down_sw),
    .dac_out          (dac_out),
    .discharge_active (discharge_active),
    .fault            (fault),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining-cycle counters per interval.
  bit            m_fault;
  bit            m_drive;
  int            m_dead;
  int            m_disch;
  logic [EW-1:0] m_up;
  logic [EW-1:0] m_dn;
  logic [EW-1:0] m_mask;
  logic [DW-1:0] m_dac;

  task automatic m_idle();
    m_fault = 0; m_drive = 0;
    m_dead  = 0; m_disch = 0;
    m_up = '0; m_dn = '0; m_mask = '0; m_dac = '0;
  endtask

  task automatic m_step();
    bit ill;
    bit nz;
    ill = |(up_req & down_req);
    nz  = |(up_req | down_req);
    if (ill || fault_in) begin
      m_fault = 1; m_drive = 0; m_dead = 0; m_disch = 0;
    end else if (m_fault) begin
      if (fault_clear && !nz) m_idle();
    end else if (!enable) begin
      m_idle();
    end else if (m_dead > 0) begin
      if (m_dead == 1) begin
        m_dead = 0;
        if (nz) begin
          m_drive = 1;
          m_up = up_req; m_dn = down_req; m_dac = dac_in;
        end else begin
          m_disch = DISCH;
        end
      end else begin
        m_dead--;
      end
    end else if (m_drive) begin
      m_mask = m_mask | m_up | m_dn;
      m_dac  = dac_in;
      if (up_req != m_up || down_req != m_dn) begin
        m_drive = 0;
        m_dead  = DEAD;
      end
    end else if (m_disch > 0) begin
      if (nz) begin
        m_disch = 0;
        m_dead  = DEAD;
      end else if (m_disch == 1) begin
        m_idle();
      end else begin
        m_disch--;
      end
    end else if (nz) begin
      m_dead = DEAD;
    end
  endtask

  logic [EW-1:0] watch_up;
  logic [EW-1:0] watch_dn;
  bit            seen;

  task automatic compare_all();
    logic [EW-1:0] e_up;
    logic [EW-1:0] e_dn;
    logic [DW-1:0] e_dac;
    e_up  = m_drive ? m_up : '0;
    e_dn  = m_drive ? m_dn : (m_disch > 0 ? m_mask : '0);
    e_dac = m_drive ? m_dac : '0;
    check("up_sw", 64'(up_sw), 64'(e_up));
    check("down_sw", 64'(down_sw), 64'(e_dn));
    check("dac_out", 64'(dac_out), 64'(e_dac));
    check("discharge_active", 64'(discharge_active),
          64'(m_disch > 0));
    check("fault", 64'(fault), 64'(m_fault));
    check("busy", 64'(busy),
          64'(m_dead > 0 || m_drive || m_disch > 0));
    check("no_shoot_through", 64'(up_sw & down_sw), 64'd0);
    if (watch_up != '0 && up_sw == watch_up &&
        down_sw == watch_dn)
      seen = 1;
  endtask

  task automatic tick(input logic [EW-1:0] u,
                      input logic [EW-1:0] d,
                      input logic [DW-1:0] dac,
                      input logic en,
                      input logic fi,
                      input logic fc);
    up_req = u; down_req = d; dac_in = dac;
    enable = en; fault_in = fi; fault_clear = fc;
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick('0, '0, '0, 1, 0, 0);
  endtask

  task automatic pulse(input logic [EW-1:0] u,
                       input logic [EW-1:0] d,
                       input int l1, input int gap,
                       input int l2, input logic [DW-1:0] dac);
    for (int i = 0; i < l1; i++) tick(u, d, dac, 1, 0, 0);
    for (int i = 0; i < gap; i++) tick('0, '0, dac, 1, 0, 0);
    for (int i = 0; i < l2; i++) tick(d, u, dac, 1, 0, 0);
  endtask

  function automatic logic [EW-1:0] onehot(input int i);
    logic [EW-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic rand_pulse();
    int a;
    int b;
    logic [EW-1:0] u;
    logic [EW-1:0] d;
    a = $urandom_range(0, EW-1);
    b = (a + $urandom_range(1, EW-1)) % EW;
    u = onehot(a);
    d = onehot(b);
    if ($urandom_range(0, 3) == 0) begin
      u = $urandom();
      d = $urandom() & ~u;
    end
    pulse(u, d, $urandom_range(1, 6), $urandom_range(0, 2),
          $urandom_range(1, 6), DW'($urandom()));
    idle_n($urandom_range(0, 12));
  endtask

  initial begin
    reset = 1; enable = 0; up_req = '0; down_req = '0;
    dac_in = '0; fault_in = 0; fault_clear = 0;
    watch_up = '0; watch_dn = '0; seen = 0;
    m_idle();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    reset = 0;

    // Biphasic pulse with 1-cycle interphase gap.
    pulse(32'h1, 32'h2, 5, 1, 5, 6'd40);
    idle_n(14);

    // Fault on overlap, held while request stays nonzero.
    tick(32'h4, 32'h4, '0, 1, 0, 0);
    tick(32'h4, 32'h0, '0, 1, 0, 1);
    tick(32'h4, 32'h0, '0, 1, 0, 1);
    tick('0, '0, '0, 1, 1, 1);
    tick('0, '0, '0, 1, 0, 1);
    idle_n(2);

    // New pulse arriving during discharge.
    pulse(32'h1, 32'h2, 4, 0, 4, 6'd17);
    idle_n(DEAD + 3);
    pulse(32'h1, 32'h2, 5, 0, 5, 6'd9);
    idle_n(14);

    // A 2-cycle phase must never reach the switches.
    pulse(32'h8, 32'h4, 5, 0, 0, 6'd5);
    watch_up = 32'h10; watch_dn = 32'h20;
    pulse(32'h10, 32'h20, 2, 0, 0, 6'd5);
    watch_up = '0;
    pulse(32'h8, 32'h4, 5, 0, 0, 6'd5);
    idle_n(14);
    check("short_phase_hidden", 64'(seen), 64'd0);

    // Disable mid-drive.
    pulse(32'h100, 32'h200, 5, 0, 0, 6'd33);
    tick(32'h100, 32'h200, 6'd33, 0, 0, 0);
    idle_n(3);

    // Asynchronous reset mid-drive, after a fault was seen.
    tick(32'h1, 32'h1, '0, 1, 0, 0);
    tick('0, '0, '0, 1, 0, 1);
    pulse(32'h40, 32'h80, 5, 0, 0, 6'd21);
    #2;
    reset = 1;
    #1;
    m_idle();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset = 0;
    idle_n(2);

    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (m_fault) tick('0, '0, '0, 1, 0, 1);
      if (r < 70) begin
        rand_pulse();
      end else if (r < 78) begin
        for (int k = 0; k < $urandom_range(1, 3); k++)
          tick(32'h3, 32'h2, '0, 1, 0, $urandom_range(0, 1));
        tick($urandom_range(0, 1) ? 32'h1 : 32'h0, '0, '0,
             1, 0, 1);
      end else if (r < 86) begin
        pulse(32'h1, 32'h2, 4, 0, 0, 6'd7);
        tick(32'h1, 32'h2, 6'd7, 1, 1, $urandom_range(0, 1));
        tick('0, '0, '0, 1, $urandom_range(0, 1), 1);
      end else if (r < 93) begin
        pulse(32'h4, 32'h8, $urandom_range(1, 5), 0, 0, 6'd3);
        for (int k = 0; k < $urandom_range(1, 3); k++)
          tick(32'h4, 32'h8, 6'd3, 0, 0, 0);
      end else begin
        logic [EW-1:0] u;
        u = $urandom();
        tick(u, $urandom() & ~u, DW'($urandom()),
             $urandom_range(0, 1), 0, $urandom_range(0, 1));
      end
    end
    idle_n(14);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
